// File: rtl/kfx86_shift_sequencer_pkg.sv
// Shared types and ALU opcode mapping for the kfx86 shift/rotate sequencer.
package kfx86_shift_sequencer_pkg;

    typedef struct packed {
        logic o;
        logic s;
        logic z;
        logic a;
        logic p;
        logic c;
    } flags_t;

    typedef enum logic [2:0] {
        SK_ROL = 3'd0,
        SK_ROR = 3'd1,
        SK_RCL = 3'd2,
        SK_RCR = 3'd3,
        SK_SHL = 3'd4,
        SK_SHR = 3'd5,
        SK_SAL = 3'd6,
        SK_SAR = 3'd7
    } shift_kind_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    localparam logic [4:0] ALU_OP_NOP = 5'h00;
    localparam logic [4:0] ALU_OP_ROL = 5'h10;
    localparam logic [4:0] ALU_OP_ROR = 5'h11;
    localparam logic [4:0] ALU_OP_RCL = 5'h12;
    localparam logic [4:0] ALU_OP_RCR = 5'h13;
    localparam logic [4:0] ALU_OP_SHL = 5'h14;
    localparam logic [4:0] ALU_OP_SHR = 5'h15;
    localparam logic [4:0] ALU_OP_SAR = 5'h17;

    function automatic logic [4:0] shift_alu_op(input shift_kind_t kind);
        logic [4:0] op;
        op = ALU_OP_NOP;
        unique case (kind)
            SK_ROL: op = ALU_OP_ROL;
            SK_ROR: op = ALU_OP_ROR;
            SK_RCL: op = ALU_OP_RCL;
            SK_RCR: op = ALU_OP_RCR;
            SK_SHL: op = ALU_OP_SHL;
            SK_SHR: op = ALU_OP_SHR;
            SK_SAL: op = ALU_OP_SHL;
            SK_SAR: op = ALU_OP_SAR;
        endcase
        return op;
    endfunction

    function automatic logic [15:0] width_mask(input logic [15:0] v, input logic word);
        return word ? v : {8'h00, v[7:0]};
    endfunction

endpackage

// File: rtl/kfx86_shift_sequencer_flag_gen.sv
// Combinational parity/zero/sign generation for an 8- or 16-bit value.
module kfx86_flag_gen (
    input  logic [15:0] value,
    input  logic        select_word,
    output logic        parity,
    output logic        zero,
    output logic        sign
);

    assign parity = ~^value[7:0];
    assign zero   = select_word ? (value == 16'h0000) : (value[7:0] == 8'h00);
    assign sign   = select_word ? value[15] : value[7];

endmodule

// File: rtl/kfx86_shift_sequencer.sv
// Iterates the ALU's single-bit shift/rotate ops `count` times for 8088
// shift/rotate-by-CL and by-1 instructions.
module kfx86_shift_sequencer
    import kfx86_shift_sequencer_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             shift_kind,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [15:0]            operand,
    input  flags_t                 operand_flags,
    input  logic                   select_word,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            result,
    output flags_t                 result_flags,
    output logic [4:0]             alu_opcode,
    output logic [15:0]            alu_source_1,
    output flags_t                 alu_source_flags,
    output logic                   alu_select_word,
    input  logic [15:0]            alu_out,
    input  flags_t                 alu_out_flags
);

    seq_state_t             state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    shift_kind_t            kind_q, kind_d;
    logic                   word_q, word_d;
    logic [15:0]            value_q, value_d;
    flags_t                 flags_q, flags_d;
    flags_t                 saved_q, saved_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [15:0]            result_q, result_d;
    flags_t                 result_flags_q, result_flags_d;
    logic [4:0]             opcode_q, opcode_d;

    logic [15:0] alu_value;
    logic        gen_p, gen_z, gen_s;
    flags_t      final_flags;

    assign alu_value = width_mask(alu_out, word_q);

    kfx86_flag_gen u_flag_gen (
        .value       (alu_value),
        .select_word (word_q),
        .parity      (gen_p),
        .zero        (gen_z),
        .sign        (gen_s)
    );

    // Shifts recompute P/Z/S from the result; rotates keep the originals.
    always_comb begin
        final_flags = alu_out_flags;
        if (kind_q inside {SK_SHL, SK_SHR, SK_SAL, SK_SAR}) begin
            final_flags.p = gen_p;
            final_flags.z = gen_z;
            final_flags.s = gen_s;
        end else begin
            final_flags.p = saved_q.p;
            final_flags.z = saved_q.z;
            final_flags.s = saved_q.s;
            final_flags.a = saved_q.a;
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        kind_d         = kind_q;
        word_d         = word_q;
        value_d        = value_q;
        flags_d        = flags_q;
        saved_d        = saved_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        result_d       = result_q;
        result_flags_d = result_flags_q;
        opcode_d       = opcode_q;
        case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    kind_d  = shift_kind_t'(shift_kind);
                    word_d  = select_word;
                    value_d = width_mask(operand, select_word);
                    flags_d = operand_flags;
                    saved_d = operand_flags;
                    busy_d  = 1'b1;
                    if (count == '0) begin
                        state_d        = SEQ_DONE;
                        done_d         = 1'b1;
                        result_d       = width_mask(operand, select_word);
                        result_flags_d = operand_flags;
                    end else begin
                        state_d     = SEQ_RUN;
                        remaining_d = count;
                        opcode_d    = shift_alu_op(shift_kind_t'(shift_kind));
                    end
                end
            end
            SEQ_RUN: begin
                value_d     = alu_value;
                flags_d     = alu_out_flags;
                remaining_d = remaining_q - COUNT_WIDTH'(1);
                if (remaining_q == COUNT_WIDTH'(1)) begin
                    state_d        = SEQ_DONE;
                    done_d         = 1'b1;
                    result_d       = alu_value;
                    result_flags_d = final_flags;
                    opcode_d       = ALU_OP_NOP;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = SEQ_IDLE;
                busy_d   = 1'b0;
                opcode_d = ALU_OP_NOP;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= SEQ_IDLE;
            remaining_q    <= '0;
            kind_q         <= SK_ROL;
            word_q         <= 1'b0;
            value_q        <= 16'h0000;
            flags_q        <= '0;
            saved_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= 16'h0000;
            result_flags_q <= '0;
            opcode_q       <= ALU_OP_NOP;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            kind_q         <= kind_d;
            word_q         <= word_d;
            value_q        <= value_d;
            flags_q        <= flags_d;
            saved_q        <= saved_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_q       <= result_d;
            result_flags_q <= result_flags_d;
            opcode_q       <= opcode_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign result           = result_q;
    assign result_flags     = result_flags_q;
    assign alu_opcode       = opcode_q;
    assign alu_source_1     = value_q;
    assign alu_source_flags = flags_q;
    assign alu_select_word  = word_q;

endmodule

// File: tb/tb_kfx86_shift_sequencer.sv
// Self-checking bench: behavioural ALU plus a reference model of the
// complete shift/rotate-by-count instruction.
module tb_kfx86_shift_sequencer;
    import kfx86_shift_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  shift_kind;
    logic [7:0]  count;
    logic [15:0] operand;
    flags_t      operand_flags;
    logic        select_word;
    logic        busy;
    logic        done;
    logic [15:0] result;
    flags_t      result_flags;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_source_1;
    flags_t      alu_source_flags;
    logic        alu_select_word;
    logic [15:0] alu_out;
    flags_t      alu_out_flags;

    int errors = 0;
    int checks = 0;
    logic [4:0] op_tab [8];

    always #5 clock = ~clock;

    kfx86_shift_sequencer #(.COUNT_WIDTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .shift_kind       (shift_kind),
        .count            (count),
        .operand          (operand),
        .operand_flags    (operand_flags),
        .select_word      (select_word),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .result_flags     (result_flags),
        .alu_opcode       (alu_opcode),
        .alu_source_1     (alu_source_1),
        .alu_source_flags (alu_source_flags),
        .alu_select_word  (alu_select_word),
        .alu_out          (alu_out),
        .alu_out_flags    (alu_out_flags)
    );

    // One x86 single-bit shift/rotate step; returns {flags, value}.
    function automatic logic [21:0] one_step(input logic [2:0] kind, input logic word,
                                              input logic [15:0] v_in, input flags_t f_in);
        int          w;
        logic [15:0] m;
        logic [15:0] v;
        logic        msb;
        logic        lsb;
        flags_t      f;
        w   = word ? 16 : 8;
        m   = word ? 16'hFFFF : 16'h00FF;
        v   = v_in & m;
        f   = f_in;
        msb = v[w-1];
        lsb = v[0];
        case (kind)
            3'd0: begin
                f.c = msb;
                v   = ((v << 1) | 16'(msb)) & m;
                f.o = v[w-1] ^ f.c;
            end
            3'd1: begin
                f.c = lsb;
                v   = (v >> 1) | (16'(lsb) << (w - 1));
                f.o = v[w-1] ^ v[w-2];
            end
            3'd2: begin
                v   = ((v << 1) | 16'(f_in.c)) & m;
                f.c = msb;
                f.o = v[w-1] ^ f.c;
            end
            3'd3: begin
                v   = (v >> 1) | (16'(f_in.c) << (w - 1));
                f.c = lsb;
                f.o = v[w-1] ^ v[w-2];
            end
            3'd5: begin
                f.c = lsb;
                f.o = msb;
                v   = v >> 1;
            end
            3'd7: begin
                f.c = lsb;
                v   = (v >> 1) | (16'(msb) << (w - 1));
                f.o = 1'b0;
            end
            default: begin
                f.c = msb;
                v   = (v << 1) & m;
                f.o = v[w-1] ^ f.c;
            end
        endcase
        f.s = v[w-1];
        f.z = (v == 16'h0000);
        f.p = ($countones(v[7:0]) % 2) == 0;
        return {f, v};
    endfunction

    logic [2:0]  alu_kind;
    logic        alu_hit;
    logic [21:0] alu_res;

    always_comb begin
        alu_kind = 3'd0;
        alu_hit  = 1'b1;
        alu_res  = 22'h0;
        case (alu_opcode)
            ALU_OP_ROL: alu_kind = 3'd0;
            ALU_OP_ROR: alu_kind = 3'd1;
            ALU_OP_RCL: alu_kind = 3'd2;
            ALU_OP_RCR: alu_kind = 3'd3;
            ALU_OP_SHL: alu_kind = 3'd4;
            ALU_OP_SHR: alu_kind = 3'd5;
            ALU_OP_SAR: alu_kind = 3'd7;
            default:    alu_hit  = 1'b0;
        endcase
        if (alu_hit)
            alu_res = one_step(alu_kind, alu_select_word, alu_source_1, alu_source_flags);
        else
            alu_res = {6'h2A, alu_source_1 ^ 16'hA5A5};
        alu_out       = alu_res[15:0];
        alu_out_flags = flags_t'(alu_res[21:16]);
    end

    // Whole-instruction model: n steps, then the architectural flag rules.
    function automatic void ref_op(input logic [2:0] kind, input int n,
                                   input logic [15:0] opnd, input flags_t f,
                                   input logic word, output logic [15:0] r,
                                   output flags_t rf);
        logic [15:0] v;
        flags_t      cur;
        logic [21:0] s;
        int          w;
        w   = word ? 16 : 8;
        v   = word ? opnd : {8'h00, opnd[7:0]};
        cur = f;
        for (int i = 0; i < n; i++) begin
            s   = one_step(kind, word, v, cur);
            v   = s[15:0];
            cur = flags_t'(s[21:16]);
        end
        rf = f;
        if (n > 0) begin
            rf.c = cur.c;
            rf.o = cur.o;
            if (kind >= 3'd4) begin
                rf.a = cur.a;
                rf.p = ($countones(v[7:0]) % 2) == 0;
                rf.z = (v == 16'h0000);
                rf.s = v[w-1];
            end
        end
        r = v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] kind, input int n, input logic [15:0] opnd,
                          input flags_t f, input logic word, input bit poke);
        logic [15:0] er;
        flags_t      ef;
        int          lat;
        ref_op(kind, n, opnd, f, word, er, ef);
        @(negedge clock);
        start         = 1'b1;
        shift_kind    = kind;
        count         = 8'(n);
        operand       = opnd;
        operand_flags = f;
        select_word   = word;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(1));
        if (n > 0)
            chk("alu_opcode_run", 32'(alu_opcode), 32'(op_tab[kind]));
        if (poke) begin
            start      = 1'b1;
            operand    = ~opnd;
            count      = 8'd3;
            shift_kind = kind ^ 3'd1;
        end
        lat = 0;
        while (!done && lat < 300) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
        end
        chk("latency", 32'(lat), 32'(n));
        chk("done_high", 32'(done), 32'(1));
        chk("busy_in_done", 32'(busy), 32'(1));
        chk("result", 32'(result), 32'(er));
        chk("result_flags", 32'(result_flags), 32'(ef));
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'(0));
        chk("busy_clear", 32'(busy), 32'(0));
        chk("result_hold", 32'(result), 32'(er));
        chk("opcode_idle", 32'(alu_opcode), 32'(ALU_OP_NOP));
    endtask

    initial begin
        op_tab = '{ALU_OP_ROL, ALU_OP_ROR, ALU_OP_RCL, ALU_OP_RCR,
                   ALU_OP_SHL, ALU_OP_SHR, ALU_OP_SHL, ALU_OP_SAR};
        reset         = 1'b1;
        start         = 1'b0;
        shift_kind    = 3'd0;
        count         = 8'd0;
        operand       = 16'h0000;
        operand_flags = '0;
        select_word   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_flags", 32'(result_flags), 32'(0));
        chk("rst_opcode", 32'(alu_opcode), 32'(ALU_OP_NOP));
        chk("rst_src", 32'(alu_source_1), 32'(0));
        chk("rst_srcflags", 32'(alu_source_flags), 32'(0));
        chk("rst_word", 32'(alu_select_word), 32'(0));
        @(negedge clock);
        reset = 1'b0;

        run_op(3'd4, 1, 16'h8001, flags_t'(6'h00), 1'b1, 1'b0);
        chk("tp_shl_res", 32'(result), 32'h0002);
        chk("tp_shl_flags", 32'({result_flags.c, result_flags.o, result_flags.z,
                                 result_flags.s, result_flags.p}), 32'b11000);
        run_op(3'd0, 4, 16'h0081, flags_t'(6'b010110), 1'b0, 1'b0);
        chk("tp_rol_res", 32'(result), 32'h0018);
        chk("tp_rol_szp", 32'({result_flags.s, result_flags.z, result_flags.p}), 32'b101);
        run_op(3'd3, 2, 16'h0001, flags_t'(6'h00), 1'b0, 1'b0);
        chk("tp_rcr_res", 32'(result), 32'h0080);
        run_op(3'd7, 3, 16'h8000, flags_t'(6'h00), 1'b1, 1'b0);
        chk("tp_sar_res", 32'(result), 32'hF000);
        chk("tp_sar_s", 32'(result_flags.s), 32'(1));
        run_op(3'd2, 0, 16'h1234, flags_t'(6'b101011), 1'b1, 1'b1);
        chk("tp_cnt0_res", 32'(result), 32'h1234);
        run_op(3'd5, 20, 16'hFFFF, flags_t'(6'h01), 1'b1, 1'b1);
        chk("tp_shr_z", 32'(result_flags.z), 32'(1));
        run_op(3'd1, 255, 16'hBEEF, flags_t'(6'h15), 1'b1, 1'b0);
        run_op(3'd4, 0, 16'hABCD, flags_t'(6'h3F), 1'b0, 1'b0);

        for (int i = 0; i < 48; i++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 24)),
                   16'($urandom), flags_t'($urandom_range(0, 63)),
                   1'($urandom), 1'($urandom));
        end

        @(negedge clock);
        start         = 1'b1;
        shift_kind    = 3'd4;
        count         = 8'd30;
        operand       = 16'h5A5A;
        operand_flags = flags_t'(6'h3F);
        select_word   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_result", 32'(result), 32'(0));
        chk("midrst_flags", 32'(result_flags), 32'(0));
        chk("midrst_opcode", 32'(alu_opcode), 32'(ALU_OP_NOP));
        chk("midrst_src", 32'(alu_source_1), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        run_op(3'd7, 5, 16'h0090, flags_t'(6'h00), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kfx86_shift_sequencer.md
# kfx86_shift_sequencer

Multi-cycle controller that runs the single-bit shift/rotate operations of the shared accumulator ALU `count` times to implement 8088 shift/rotate-by-CL (and by-1) instructions. It feeds the ALU output and flags back as the ALU input on each iteration, one iteration per clock, and returns the final result and flags to the execution unit. It sits between the execution-unit microsequencer and the ALU. It owns the ALU's inputs only while `busy` is high; arbitration with other users is external.

## Interface
- `COUNT_WIDTH`, default 8: width of the shift count. 8088 semantics apply: the count is not masked to 5 bits.
- `clock`  in  1  — single clock, all state on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — request pulse. Sampled only in IDLE.
- `shift_kind`  in  3  — x86 ModRM reg encoding: 0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SAL (=SHL), 7 SAR.
- `count`  in  COUNT_WIDTH  — iteration count, captured with `start`.
- `operand`  in  16  — value to shift, captured with `start`.
- `operand_flags`  in  flags_t  — flags, captured with `start`.
- `select_word`  in  1  — 1 = 16-bit, 0 = 8-bit. Captured with `start`.
- `busy`  out  1  — high from the cycle after `start` until `done`, inclusive.
- `done`  out  1  — one-cycle pulse. `result`/`result_flags` are valid in this cycle and held until the next `start`.
- `result`  out  16  — final value. Upper byte is 0 in byte mode.
- `result_flags`  out  flags_t  — final flags.
- `alu_opcode`  out  5  — ALU opcode driven to the ALU.
- `alu_source_1`  out  16  — running value.
- `alu_source_flags`  out  flags_t  — running flags.
- `alu_select_word`  out  1  — captured width.
- `alu_out`  in  16  — ALU result.
- `alu_out_flags`  in  flags_t  — ALU flags.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE.** On `start`, capture count/kind/width into registers. Set the value register to `operand` (byte mode: upper byte forced to 0) and the flag register to `operand_flags`.
  - If count == 0, go to DONE.
  - Otherwise go to RUN with remaining = count.
- **RUN.** Each cycle, latch `alu_out` → value and `alu_out_flags` → flags, and decrement remaining. When remaining reaches 1 in that cycle, the next state is DONE.
- **DONE.** Pulse `done` and drive the outputs, then go to IDLE.
  - Results are held in output registers until the next `start`.
- **ALU opcode mapping.** `alu_opcode` is mapped from `shift_kind` to `ALU_OP_ROL/ROR/RCL/RCR/SHL/SHR/SHL/SAR`.
  - It is driven only in RUN. Elsewhere it is the ALU default/no-op code.
- **Final flags.**
  - C, O: from the last iteration.
  - Kinds 4–7: the sequencer recomputes P (even parity of result[7:0]), Z (result, width-masked, == 0) and S (bit 15 or bit 7 per width) from the final value.
  - Kinds 0–3: P, Z, S and A are unchanged from `operand_flags`.
  - Count 0: all flags equal `operand_flags` and `result` = width-masked `operand`.
- `start` while `busy` is ignored; no queueing.
- `reset` in any state returns to IDLE on the next edge.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `result_flags`=0, `alu_opcode`=no-op, `alu_source_1`=0, `alu_source_flags`=0, `alu_select_word`=0.
- **Count N>0.** With `start` at edge T:
  - RUN covers cycles T+1 … T+N.
  - `done` is high in cycle T+N+1.
  - Latency is N+1 cycles.
- **Count 0.** `done` is high in cycle T+1.
- **ALU path.** The ALU is combinational: `alu_source_1`/`alu_source_flags` come directly from registers, and `alu_out` is latched at the same edge. There is one iteration per cycle and no ALU pipeline stage.
- **Back-to-back operation.** `start` may be reasserted in the cycle after DONE (IDLE).
- **Maximum count.** Count 255 gives 256 cycles. The decrementer never underflows.
- **Reset mid-RUN.** `busy`=0 and `done`=0 on the next cycle. The partial result is discarded and outputs return to reset values.

## Structure
- The shared package holds:
  - the `flags_t` typedef;
  - a `shift_kind_t` enum (3-bit, values above);
  - a `seq_state_t` enum;
  - the shift_kind→ALU opcode mapping function, reusing the existing `ALU_OP_*` defines from the ALU header.
- One sub-module is natural: `kfx86_flag_gen` (combinational P/Z/S from value + width). It is reusable by other sequencers.
- The ALU itself is instantiated outside; this block only drives its ports.

## Test plan
- SHL word, operand 0x8001, count 1 → `done` at T+2. `result`=0x0002, C=1, O=1, Z=0, S=0, P=0.
- ROL byte, operand 0x81, count 4 → `done` at T+5. `result`=0x0018, C=0, O=0, and P/Z/S equal the input flags.
- RCR byte, operand 0x01, CF=0, count 2 → `result`=0x0080, C=0.
- SAR word, operand 0x8000, count 3 → `result`=0xF000, C=0, S=1, Z=0, O=0.
- Count 0 with any kind → `done` at T+1. `result`=operand and `result_flags`=`operand_flags`. A `start` pulse during `busy` is ignored.
- SHR word, operand 0xFFFF, count 20 (unmasked) → `result`=0x0000, Z=1, C=0, `done` at T+21.
- Reset asserted mid-RUN → `busy`=0 next cycle, outputs at reset values, and a new `start` then completes normally.
